capture_readout: RTL and testbench

- Readout end of the capture path. Runs after the capture FSM has frozen the sample FIFO and raised ENOUT.
- Drains the FIFO one sample at a time and serializes each sample into bytes on a valid/ready byte stream toward the host link.
- Frames the dump with a header byte and a trailer carrying the sample count.
- Raises FinishRD so the capture FSM can advance to its clear phase.

---
 rtl/capture_readout_pkg.sv | 28 ++
 rtl/capture_readout_if.sv | 12 +
 rtl/capture_readout_byte_serializer.sv | 38 +++
 rtl/capture_readout.sv | 132 +++++++++++++
 tb/tb_capture_readout.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/capture_readout_pkg.sv
// Shared definitions for the capture readout path: FSM state encoding, default
// framing bytes and the byte-stream handshake rule.
package capture_readout_pkg;

  typedef enum logic [3:0] {
    IDLE,
    HDR,
    FETCH,
    WAITQ,
    SEND,
    TRL0,
    TRL1,
    TRL2,
    DONE
  } cr_state_e;

  localparam logic [7:0] DEF_HDR_BYTE = 8'hA5;
  localparam logic [7:0] DEF_TRL_BYTE = 8'h5A;
  localparam int unsigned CNT_W = 16;

  typedef logic [7:0] tx_byte_t;

  // A byte moves on any clock edge where both sides agree.
  function automatic logic tx_fire(input logic valid, input logic ready);
    return valid & ready;
  endfunction

endpackage

// File: rtl/capture_readout_if.sv
// Valid/ready byte stream from the readout block toward the host link.
interface capture_readout_if;
  import capture_readout_pkg::*;

  tx_byte_t TxData;
  logic     TxValid;
  logic     TxReady;

  modport master (output TxData, output TxValid, input TxReady);
  modport slave  (input TxData, input TxValid, output TxReady);

endinterface

// File: rtl/capture_readout_byte_serializer.sv
// SAMPLE_W-to-byte shift register; emits the least-significant byte first and
// flags the final byte of the loaded sample.
module capture_readout_byte_serializer #(
  parameter int unsigned SAMPLE_W = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                load,
  input  logic                advance,
  input  logic [SAMPLE_W-1:0] din,
  output logic [7:0]          dout,
  output logic                last
);

  localparam int unsigned NB = SAMPLE_W / 8;
  localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

  logic [SAMPLE_W-1:0] sr;
  logic [IW-1:0]       idx;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sr  <= '0;
      idx <= '0;
    end else if (load) begin
      sr  <= din;
      idx <= '0;
    end else if (advance) begin
      sr  <= sr >> 8;
      idx <= idx + 1'b1;
    end
  end

  assign dout = sr[7:0];
  assign last = (idx == LAST_IDX);

endmodule

// File: rtl/capture_readout.sv
// Drains the frozen sample FIFO and frames it as HDR, sample bytes, count lo/hi,
// TRL on the host byte stream, then raises FinishRD until ENOUT drops.
module capture_readout
  import capture_readout_pkg::*;
#(
  parameter int unsigned SAMPLE_W    = 16,
  parameter int unsigned MAX_SAMPLES = 1024,
  parameter logic [7:0]  HDR_BYTE    = DEF_HDR_BYTE,
  parameter logic [7:0]  TRL_BYTE    = DEF_TRL_BYTE
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                ENOUT,
  input  logic                rdempty,
  input  logic [SAMPLE_W-1:0] q,
  output logic                rdreq,
  capture_readout_if.master   tx,
  output logic                FinishRD,
  output logic                busy
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_SAMPLES);

  cr_state_e        state;
  logic [CNT_W-1:0] count;
  logic             tx_valid;
  tx_byte_t         tx_data;
  logic             fire;
  logic             abort;
  logic [7:0]       ser_byte;
  logic             ser_last;

  assign fire  = tx_fire(tx_valid, tx.TxReady);
  assign abort = !ENOUT && (state != IDLE) && (state != DONE);

  // Combinational so the FIFO sees the request during FETCH and q lands in WAITQ.
  assign rdreq = (state == FETCH) && ENOUT && !rdempty && (count != MAX_CNT);
  assign busy  = (state != IDLE);

  capture_readout_byte_serializer #(
    .SAMPLE_W (SAMPLE_W)
  ) u_ser (
    .CLK     (CLK),
    .RST     (RST),
    .load    ((state == WAITQ) && ENOUT),
    .advance ((state == SEND) && fire),
    .din     (q),
    .dout    (ser_byte),
    .last    (ser_last)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      count    <= '0;
      tx_valid <= 1'b0;
      FinishRD <= 1'b0;
    end else if (abort) begin
      state    <= IDLE;
      tx_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ENOUT) begin
            count    <= '0;
            tx_valid <= 1'b1;
            state    <= HDR;
          end
        end
        HDR: begin
          if (fire) begin
            tx_valid <= 1'b0;
            state    <= FETCH;
          end
        end
        FETCH: begin
          if (rdempty || (count == MAX_CNT)) begin
            tx_valid <= 1'b1;
            state    <= TRL0;
          end else begin
            state <= WAITQ;
          end
        end
        WAITQ: begin
          count    <= count + 1'b1;
          tx_valid <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          if (fire && ser_last) begin
            tx_valid <= 1'b0;
            state    <= FETCH;
          end
        end
        TRL0: if (fire) state <= TRL1;
        TRL1: if (fire) state <= TRL2;
        TRL2: begin
          if (fire) begin
            tx_valid <= 1'b0;
            FinishRD <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          if (!ENOUT) begin
            FinishRD <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    tx_data = '0;
    if (tx_valid) begin
      unique case (state)
        HDR:     tx_data = HDR_BYTE;
        SEND:    tx_data = ser_byte;
        TRL0:    tx_data = count[7:0];
        TRL1:    tx_data = count[15:8];
        TRL2:    tx_data = TRL_BYTE;
        default: tx_data = '0;
      endcase
    end
  end

  assign tx.TxData  = tx_data;
  assign tx.TxValid = tx_valid;

endmodule

// File: tb/tb_capture_readout.sv
// Randomized bench for capture_readout: a FIFO model feeds the DUT, and every
// dump is compared against a frame list built from the loaded samples.
module tb_capture_readout;

  localparam int unsigned SW   = 16;
  localparam int unsigned MAXS = 1024;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ENOUT = 1'b0;
  logic        rdempty;
  logic [15:0] q = '0;
  logic        rdreq;
  logic        FinishRD;
  logic        busy;

  capture_readout_if tx_if();

  capture_readout #(
    .SAMPLE_W    (SW),
    .MAX_SAMPLES (MAXS)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .ENOUT    (ENOUT),
    .rdempty  (rdempty),
    .q        (q),
    .rdreq    (rdreq),
    .tx       (tx_if),
    .FinishRD (FinishRD),
    .busy     (busy)
  );

  initial forever #5 CLK = ~CLK;

  // Non-show-ahead FIFO: q is valid the cycle after rdreq is seen.
  logic [15:0] mem [0:4095];
  int          rd_ptr = 0;
  int          fifo_end = 0;
  assign rdempty = (rd_ptr >= fifo_end);

  always @(posedge CLK) begin
    if (rdreq) begin
      q      <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  int checks = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, want);
  endtask

  int ready_pct = 100;

  initial begin
    tx_if.TxReady = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      tx_if.TxReady = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Monitor at the falling edge: what is seen here transfers on the next rising edge.
  logic [7:0] rx [$];
  int         rdreq_cnt = 0;
  int         cyc = 0;
  int         last_xfer_cyc = 0;
  bit         stall_chk = 1'b0;
  logic       pv = 1'b0;
  logic       pr = 1'b0;
  logic [7:0] pd = '0;

  initial forever begin
    @(negedge CLK);
    cyc++;
    if (stall_chk && pv && !pr) check("stall_hold", {tx_if.TxValid, tx_if.TxData}, {1'b1, pd});
    if (rdreq) begin
      rdreq_cnt++;
      check("rdreq_while_empty", rdempty, 0);
    end
    if (tx_if.TxValid && tx_if.TxReady) begin
      rx.push_back(tx_if.TxData);
      last_xfer_cyc = cyc;
    end
    pv = tx_if.TxValid;
    pr = tx_if.TxReady;
    pd = tx_if.TxData;
  end

  logic [15:0] src [0:2047];
  logic [7:0]  exp_q [$];

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  // Expected dump: header, each read sample LSB first, 16-bit count LSB first, trailer.
  task automatic load_fifo(input int n);
    int k;
    for (int i = 0; i < n; i++) mem[rd_ptr + i] = src[i];
    fifo_end = rd_ptr + n;
    k = (n < MAXS) ? n : MAXS;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int i = 0; i < k; i++) begin
      exp_q.push_back(src[i] % 256);
      exp_q.push_back(src[i] / 256);
    end
    exp_q.push_back(8'(k % 256));
    exp_q.push_back(8'(k / 256));
    exp_q.push_back(8'h5A);
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) src[i] = 16'($urandom);
  endtask

  task automatic start_dump();
    rx.delete();
    rdreq_cnt = 0;
    ENOUT = 1'b1;
    tick();
    check("start_valid", tx_if.TxValid, 1);
    check("start_hdr", tx_if.TxData, 8'hA5);
  endtask

  task automatic wait_finish();
    for (int i = 0; i < 20000; i++) begin
      tick();
      if (FinishRD) break;
    end
    if (!FinishRD) check("finish_timeout", 0, 1);
    else check("finish_lat", cyc, last_xfer_cyc);
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_len"}, rx.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < rx.size()) check(tag, rx[i], exp_q[i]);
  endtask

  task automatic release_enout();
    ENOUT = 1'b0;
    tick();
    check("finish_fall", FinishRD, 0);
    check("idle_busy", busy, 0);
  endtask

  task automatic full_dump(input string tag, input int n);
    load_fifo(n);
    start_dump();
    wait_finish();
    compare_stream(tag);
    check({tag, "_rdreq"}, rdreq_cnt, (n < MAXS) ? n : MAXS);
    release_enout();
  endtask

  logic [7:0] lit [0:9];

  initial begin
    lit = '{8'hA5, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h01, 8'h00, 8'h03, 8'h00, 8'h5A};

    repeat (3) @(posedge CLK);
    #2;
    check("rst_valid", tx_if.TxValid, 0);
    check("rst_data", tx_if.TxData, 0);
    check("rst_rdreq", rdreq, 0);
    check("rst_finish", FinishRD, 0);
    check("rst_busy", busy, 0);
    RST = 1'b0;
    tick();
    tick();
    check("idle_hold", {busy, tx_if.TxValid}, 0);

    // Three known samples, host always ready.
    src[0] = 16'h1234; src[1] = 16'hABCD; src[2] = 16'h0001;
    load_fifo(3);
    start_dump();
    wait_finish();
    compare_stream("s1");
    for (int i = 0; i < 10; i++)
      if (i < rx.size()) check("s1_literal", rx[i], lit[i]);
    check("s1_rdreq", rdreq_cnt, 3);
    tick();
    tick();
    check("finish_hold", FinishRD, 1);
    check("done_busy", busy, 1);
    release_enout();

    // Empty FIFO.
    full_dump("empty", 0);

    // Oversized FIFO capped at MAX_SAMPLES.
    fill_random(2000);
    full_dump("cap", 2000);

    // Backpressure at 30% ready.
    src[0] = 16'h1234; src[1] = 16'hABCD;
    ready_pct = 30;
    stall_chk = 1'b1;
    full_dump("bp", 2);
    stall_chk = 1'b0;
    ready_pct = 100;

    // Abort while the second byte of the first sample is on the bus.
    fill_random(3);
    load_fifo(3);
    start_dump();
    for (int i = 0; i < 100; i++) begin
      if (rx.size() == 2) break;
      tick();
    end
    ENOUT = 1'b0;
    tick();
    check("abort_valid", tx_if.TxValid, 0);
    check("abort_busy", busy, 0);
    check("abort_finish", FinishRD, 0);
    check("abort_len", rx.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < rx.size()) check("abort_bytes", rx[i], exp_q[i]);
    check("abort_rdreq", rdreq_cnt, 1);
    repeat (3) tick();
    check("abort_no_finish", {FinishRD, tx_if.TxValid}, 0);
    fill_random(2);
    full_dump("restart", 2);

    // Reset in the middle of SEND.
    fill_random(4);
    load_fifo(4);
    start_dump();
    for (int i = 0; i < 100; i++) begin
      if (rx.size() == 4) break;
      tick();
    end
    check("pre_rst_valid", tx_if.TxValid, 1);
    RST = 1'b1;
    #1;
    check("arst_valid", tx_if.TxValid, 0);
    check("arst_data", tx_if.TxData, 0);
    check("arst_rdreq", rdreq, 0);
    check("arst_busy", busy, 0);
    check("arst_finish", FinishRD, 0);
    tick();
    tick();
    rx.delete();
    rdreq_cnt = 0;
    fill_random(3);
    load_fifo(3);
    RST = 1'b0;
    tick();
    check("post_rst_valid", tx_if.TxValid, 1);
    check("post_rst_hdr", tx_if.TxData, 8'hA5);
    wait_finish();
    compare_stream("post_rst");
    check("post_rst_rdreq", rdreq_cnt, 3);
    release_enout();

    // Random sizes and backpressure.
    stall_chk = 1'b1;
    for (int t = 0; t < 4; t++) begin
      int n;
      n = $urandom_range(0, 6);
      ready_pct = $urandom_range(20, 100);
      fill_random(n);
      full_dump("rand", n);
    end
    stall_chk = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
